// File: rtl/rf_wb_if.sv
// Write-back scheduler bus: multi-cycle issue/result handshake, decode hazard
// check, pipeline write-back request and the register-file write port.
interface rf_wb_if;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        chk_valid;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        p_we;
    logic [4:0]  p_wr;
    logic [31:0] p_wd;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;
    logic        hazard;
    logic        err;

    modport master (
        output iss_valid, iss_rd, chk_valid, chk_rs1, chk_rs2, chk_rd,
               p_we, p_wr, p_wd, m_valid, m_rd, m_wd,
        input  m_ready, rf_we, rf_wR, rf_wD, hazard, err
    );

    modport slave (
        input  iss_valid, iss_rd, chk_valid, chk_rs1, chk_rs2, chk_rd,
               p_we, p_wr, p_wd, m_valid, m_rd, m_wd,
        output m_ready, rf_we, rf_wR, rf_wD, hazard, err
    );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-port arbiter: pipeline write-back has priority, a
// one-entry buffer holds a blocked multi-cycle result, and a busy scoreboard
// drives the decode stall.
module rf_wb_sched #(
    parameter int MAX_WAIT = 4
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [31:0] buf_wd_q, buf_wd_d;
    logic [31:0] busy_q, busy_d;
    logic        err_q, err_set;
    logic        wr_req;
    logic [4:0]  wr_rd;
    logic [31:0] wr_wd;
    logic        clr_en;
    logic [4:0]  clr_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            buf_rd_q <= '0;
            buf_wd_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            buf_rd_q <= buf_rd_d;
            buf_wd_q <= buf_wd_d;
            busy_q   <= busy_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        buf_rd_d    = buf_rd_q;
        buf_wd_d    = buf_wd_q;
        wr_req      = 1'b0;
        wr_rd       = bus.p_wr;
        wr_wd       = bus.p_wd;
        clr_en      = 1'b0;
        clr_rd      = buf_rd_q;
        err_set     = 1'b0;
        bus.m_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.m_ready = 1'b1;
                if (bus.p_we) begin
                    wr_req = 1'b1;
                    if (bus.m_valid) begin
                        buf_rd_d = bus.m_rd;
                        buf_wd_d = bus.m_wd;
                        wait_d   = '0;
                        state_d  = HOLD;
                    end
                end else if (bus.m_valid) begin
                    wr_req = 1'b1;
                    wr_rd  = bus.m_rd;
                    wr_wd  = bus.m_wd;
                    clr_en = 1'b1;
                    clr_rd = bus.m_rd;
                end
            end
            HOLD: begin
                wr_req = 1'b1;
                if (bus.p_we) begin
                    wait_d = wait_q + 4'd1;
                    if (wait_q == 4'(MAX_WAIT - 1)) state_d = FORCE;
                end else begin
                    wr_rd   = buf_rd_q;
                    wr_wd   = buf_wd_q;
                    clr_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            FORCE: begin
                // Pipeline is stalled by hazard; any p_we here is a protocol error.
                wr_req  = 1'b1;
                wr_rd   = buf_rd_q;
                wr_wd   = buf_wd_q;
                clr_en  = 1'b1;
                err_set = bus.p_we;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Set after clear so a same-edge reissue of the register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 5'd0) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign bus.rf_we  = wr_req && (wr_rd != 5'd0);
    assign bus.rf_wR  = wr_rd;
    assign bus.rf_wD  = wr_wd;
    assign bus.err    = err_q;
    assign bus.hazard = (state_q == FORCE) ||
                        (bus.chk_valid && (busy_q[bus.chk_rs1] || busy_q[bus.chk_rs2] ||
                                           busy_q[bus.chk_rd]));
endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus randomized
// traffic against a queue-based model of the write-port arbitration.
module tb_rf_wb_sched;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_if bus ();
    rf_wb_sched #(.MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;

    // Model: pending blocked results, how many cycles the head has lost arbitration.
    bit [31:0]   mbusy;
    logic [4:0]  q_rd[$];
    logic [31:0] q_wd[$];
    int          blocked;
    bit          merr;

    // Values sampled by the last tick, for directed literal checks.
    logic d_ready, d_we, d_haz, d_err;
    logic [4:0]  d_wr;
    logic [31:0] d_wd;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.chk_valid = 0; bus.chk_rs1 = 0; bus.chk_rs2 = 0; bus.chk_rd = 0;
        bus.p_we = 0; bus.p_wr = 0; bus.p_wd = 0;
        bus.m_valid = 0; bus.m_rd = 0; bus.m_wd = 0;
    endtask

    function automatic void model_clear();
        mbusy = 0; q_rd.delete(); q_wd.delete(); blocked = 0; merr = 0;
    endfunction

    // One clock: predict from the model, compare at negedge, advance at posedge.
    task automatic tick();
        bit forced, pend, wv, clr, pop, push, bump;
        logic [4:0] wr, crd;
        logic [31:0] wd;
        logic e_ready, e_we, e_haz, e_err;
        pend = q_rd.size() != 0;
        forced = pend && blocked == MW;
        wv = 0; clr = 0; pop = 0; push = 0; bump = 0; wr = 0; wd = 0; crd = 0;
        if (forced) begin
            wv = 1; wr = q_rd[0]; wd = q_wd[0]; clr = 1; crd = wr; pop = 1;
        end else if (pend) begin
            wv = 1;
            if (bus.p_we) begin wr = bus.p_wr; wd = bus.p_wd; bump = 1; end
            else begin wr = q_rd[0]; wd = q_wd[0]; clr = 1; crd = wr; pop = 1; end
        end else if (bus.p_we) begin
            wv = 1; wr = bus.p_wr; wd = bus.p_wd; push = bus.m_valid;
        end else if (bus.m_valid) begin
            wv = 1; wr = bus.m_rd; wd = bus.m_wd; clr = 1; crd = wr;
        end
        e_ready = !pend;
        e_we    = wv && wr != 0;
        e_haz   = forced || (bus.chk_valid &&
                  (mbusy[bus.chk_rs1] || mbusy[bus.chk_rs2] || mbusy[bus.chk_rd]));
        e_err   = merr;
        @(negedge clk);
        d_ready = bus.m_ready; d_we = bus.rf_we; d_wr = bus.rf_wR; d_wd = bus.rf_wD;
        d_haz = bus.hazard; d_err = bus.err;
        chk("m_ready", d_ready, e_ready);
        chk("rf_we", d_we, e_we);
        if (e_we) begin
            chk("rf_wR", d_wr, wr);
            chk("rf_wD", d_wd, wd);
        end
        chk("hazard", d_haz, e_haz);
        chk("err", d_err, e_err);
        @(posedge clk);
        if (!rst) begin
            if (forced && bus.p_we) merr = 1;
            if (pop) begin void'(q_rd.pop_front()); void'(q_wd.pop_front()); end
            if (push) begin q_rd.push_back(bus.m_rd); q_wd.push_back(bus.m_wd); blocked = 0; end
            if (bump) blocked++;
            if (clr) mbusy[crd] = 0;
            if (bus.iss_valid && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; model_clear();
        tick();
        rst = 0;
    endtask

    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    int          p_pct;

    initial begin
        idle();
        rst = 1;
        model_clear();
        #2;
        chk("reset_m_ready", bus.m_ready, 1);
        chk("reset_rf_we", bus.rf_we, 0);
        chk("reset_hazard", bus.hazard, 0);
        chk("reset_err", bus.err, 0);
        @(posedge clk); #1;
        do_reset();

        // Issue x5, then its result written directly while decode sees the hazard.
        bus.iss_valid = 1; bus.iss_rd = 5; tick(); idle();
        bus.chk_valid = 1; bus.chk_rs1 = 5;
        bus.m_valid = 1; bus.m_rd = 5; bus.m_wd = 32'h1234; tick();
        chk("t1_hazard", d_haz, 1);
        chk("t1_we", d_we, 1); chk("t1_wR", d_wr, 5); chk("t1_wD", d_wd, 32'h1234);
        idle(); bus.chk_valid = 1; bus.chk_rs1 = 5; tick();
        chk("t1_hazard_clear", d_haz, 0);

        // Conflict: pipeline wins, result buffered, drained next free cycle.
        idle(); bus.p_we = 1; bus.p_wr = 3; bus.p_wd = 32'hAA;
        bus.m_valid = 1; bus.m_rd = 7; bus.m_wd = 32'hBB; tick();
        chk("t2_wR", d_wr, 3); chk("t2_wD", d_wd, 32'hAA); chk("t2_ready", d_ready, 1);
        idle(); tick();
        chk("t2_buf_wR", d_wr, 7); chk("t2_buf_wD", d_wd, 32'hBB); chk("t2_buf_ready", d_ready, 0);
        tick();
        chk("t2_idle_ready", d_ready, 1);

        // Starvation: four blocked cycles, then the buffer is forced out.
        idle(); bus.p_we = 1; bus.p_wr = 4; bus.p_wd = 32'h44;
        bus.m_valid = 1; bus.m_rd = 11; bus.m_wd = 32'hCAFE; tick();
        bus.m_valid = 0;
        for (int i = 0; i < MW; i++) begin
            tick();
            chk("t3_hold_wR", d_wr, 4);
            chk("t3_hold_haz", d_haz, 0);
        end
        tick();
        chk("t3_force_haz", d_haz, 1); chk("t3_force_wR", d_wr, 11);
        chk("t3_force_wD", d_wd, 32'hCAFE); chk("t3_force_ready", d_ready, 0);
        idle(); tick();
        chk("t3_err", d_err, 1); chk("t3_after_ready", d_ready, 1);
        tick();
        chk("t3_err_sticky", d_err, 1);
        do_reset();

        // x0: result consumed without a write; issue to x0 never marks busy.
        idle(); bus.m_valid = 1; bus.m_rd = 0; bus.m_wd = 32'h55; tick();
        chk("t4_ready", d_ready, 1); chk("t4_we", d_we, 0);
        idle(); bus.iss_valid = 1; bus.iss_rd = 0; tick();
        idle(); bus.chk_valid = 1; bus.chk_rs1 = 0; tick();
        chk("t4_haz", d_haz, 0);

        // Same-edge clear and reissue of x9: set wins.
        idle(); bus.iss_valid = 1; bus.iss_rd = 9; tick();
        idle(); bus.iss_valid = 1; bus.iss_rd = 9;
        bus.m_valid = 1; bus.m_rd = 9; bus.m_wd = 32'h99; tick();
        chk("t5_we", d_we, 1); chk("t5_wR", d_wr, 9);
        idle(); bus.chk_valid = 1; bus.chk_rs2 = 9; tick();
        chk("t5_haz", d_haz, 1);

        // Reset with the buffer full: data is discarded, busy cleared.
        idle(); bus.iss_valid = 1; bus.iss_rd = 12; tick();
        idle(); bus.p_we = 1; bus.p_wr = 2; bus.p_wd = 32'h22;
        bus.m_valid = 1; bus.m_rd = 12; bus.m_wd = 32'hDEAD; tick();
        idle(); bus.p_we = 1; bus.p_wr = 2; tick();
        chk("t6_pre_ready", d_ready, 0);
        idle(); bus.chk_valid = 1; bus.chk_rs1 = 12;
        rst = 1; #1;
        chk("t6_async_ready", bus.m_ready, 1);
        chk("t6_async_we", bus.rf_we, 0);
        chk("t6_async_haz", bus.hazard, 0);
        model_clear(); tick(); rst = 0;
        idle(); tick();
        chk("t6_no_write", d_we, 0); chk("t6_ready", d_ready, 1);

        // Randomized traffic; the result source holds its request until accepted.
        mv = 0; mrd = 0; mwd = 0; d_ready = 1; p_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) p_pct = $urandom_range(30, 95);
            if (!mv || d_ready) begin
                mv  = ($urandom_range(0, 99) < 45);
                mrd = 5'($urandom_range(0, 15));
                mwd = $urandom;
            end
            bus.m_valid = mv; bus.m_rd = mrd; bus.m_wd = mwd;
            bus.p_we = ($urandom_range(0, 99) < p_pct);
            bus.p_wr = 5'($urandom_range(0, 31)); bus.p_wd = $urandom;
            bus.iss_valid = ($urandom_range(0, 99) < 30);
            bus.iss_rd = 5'($urandom_range(0, 15));
            bus.chk_valid = $urandom_range(0, 1);
            bus.chk_rs1 = 5'($urandom_range(0, 15));
            bus.chk_rs2 = 5'($urandom_range(0, 15));
            bus.chk_rd  = 5'($urandom_range(0, 15));
            tick();
            if ($urandom_range(0, 399) == 0) begin
                idle(); mv = 0; d_ready = 1;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
